// File: rtl/traffic_pkg.sv
// Shared encodings for the UK traffic-light sequencer and its monitor:
// phases, lamp patterns, error codes and monitor states.
package traffic_pkg;

   typedef enum logic [1:0] {
      RED       = 2'd0,
      RED_AMBER = 2'd1,
      GREEN     = 2'd2,
      AMBER     = 2'd3
   } phase_e;

   // Lamp patterns are packed as {green, amber, red}
   localparam logic [2:0] PAT_RED       = 3'b001;
   localparam logic [2:0] PAT_RED_AMBER = 3'b011;
   localparam logic [2:0] PAT_GREEN     = 3'b100;
   localparam logic [2:0] PAT_AMBER     = 3'b010;

   typedef enum logic [1:0] {
      ERR_NONE    = 2'd0,
      ERR_PATTERN = 2'd1,
      ERR_TRANS   = 2'd2,
      ERR_DWELL   = 2'd3
   } err_e;

   typedef enum logic {
      UNSYNC = 1'b0,
      LOCKED = 1'b1
   } mon_state_e;

   // The legal sequence is a simple modulo-4 walk through the phase encoding
   function automatic phase_e next_phase(input phase_e p);
      logic [1:0] n;
      n = p + 2'd1;
      return phase_e'(n);
   endfunction

endpackage

// File: rtl/traffic_monitor_light_decode.sv
// Combinational lamp-pattern decoder: maps {green, amber, red} to a phase
// and flags whether the pattern is one of the four legal ones.
module light_decode
   import traffic_pkg::*;
(
   input  logic [2:0] pattern,
   output phase_e     phase,
   output logic       legal
);

   always_comb begin
      phase = RED;
      legal = 1'b1;
      case (pattern)
         PAT_RED:       phase = RED;
         PAT_RED_AMBER: phase = RED_AMBER;
         PAT_GREEN:     phase = GREEN;
         PAT_AMBER:     phase = AMBER;
         default:       legal = 1'b0;
      endcase
   end

endmodule

// File: rtl/traffic_monitor.sv
// Observer/checker for the UK traffic-light sequence: locks on RED, checks
// every pattern and transition, counts cycles. Optional dwell timeout is
// enabled by defining TRAFFIC_MON_DWELL_EN.
module traffic_monitor
   import traffic_pkg::*;
#(
   parameter int CNT_W     = 8,
   parameter int MAX_DWELL = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             red,
   input  logic             amber,
   input  logic             green,
   input  logic             clr_err,
   output logic [1:0]       phase,
   output logic             locked,
   output logic             err_pulse,
   output logic             err_sticky,
   output logic [1:0]       err_code,
   output logic [CNT_W-1:0] seq_count
);

   if (MAX_DWELL < 1 || MAX_DWELL > 65535) begin : g_bad_max_dwell
      $error("traffic_monitor: MAX_DWELL out of range 1..65535");
   end

   phase_e     dec_phase;
   logic       dec_legal;

   light_decode u_decode (
      .pattern ({green, amber, red}),
      .phase   (dec_phase),
      .legal   (dec_legal)
   );

   mon_state_e       state_q,      state_d;
   phase_e           phase_q,      phase_d;
   logic             err_pulse_q,  err_pulse_d;
   logic             err_sticky_q, err_sticky_d;
   err_e             err_code_q,   err_code_d;
   logic [CNT_W-1:0] seq_count_q,  seq_count_d;

   logic             err_hit;
   err_e             err_new;
   logic             dwell_expired;
   logic             dwell_clear;
   logic             dwell_inc;

`ifdef TRAFFIC_MON_DWELL_EN
   localparam int DWELL_W = $clog2(MAX_DWELL + 1);
   logic [DWELL_W-1:0] dwell_q, dwell_d;

   // A hold sample lands MAX_DWELL cycles past the first sample when the
   // count of earlier holds has reached MAX_DWELL-1.
   assign dwell_expired = (dwell_q == DWELL_W'(MAX_DWELL - 1));

   always_comb begin
      dwell_d = dwell_q;
      if (dwell_clear) begin
         dwell_d = '0;
      end else if (dwell_inc) begin
         dwell_d = dwell_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         dwell_q <= '0;
      end else begin
         dwell_q <= dwell_d;
      end
   end
`else
   assign dwell_expired = 1'b0;
`endif

   always_comb begin
      state_d      = state_q;
      phase_d      = phase_q;
      err_pulse_d  = 1'b0;
      err_sticky_d = err_sticky_q;
      err_code_d   = err_code_q;
      seq_count_d  = seq_count_q;
      err_hit      = 1'b0;
      err_new      = ERR_NONE;
      dwell_clear  = 1'b0;
      dwell_inc    = 1'b0;

      case (state_q)
         UNSYNC: begin
            if (!dec_legal) begin
               err_hit = 1'b1;
               err_new = ERR_PATTERN;
            end else if (dec_phase == RED) begin
               state_d     = LOCKED;
               phase_d     = RED;
               dwell_clear = 1'b1;
            end
         end
         LOCKED: begin
            if (!dec_legal) begin
               err_hit     = 1'b1;
               err_new     = ERR_PATTERN;
               state_d     = UNSYNC;
               dwell_clear = 1'b1;
            end else if (dec_phase == phase_q) begin
               if (dwell_expired) begin
                  err_hit     = 1'b1;
                  err_new     = ERR_DWELL;
                  state_d     = UNSYNC;
                  dwell_clear = 1'b1;
               end else begin
                  dwell_inc = 1'b1;
               end
            end else if (dec_phase == next_phase(phase_q)) begin
               phase_d     = dec_phase;
               dwell_clear = 1'b1;
               if (phase_q == AMBER && seq_count_q != '1) begin
                  seq_count_d = seq_count_q + 1'b1;
               end
            end else begin
               err_hit     = 1'b1;
               err_new     = ERR_TRANS;
               state_d     = UNSYNC;
               dwell_clear = 1'b1;
            end
         end
         default: state_d = UNSYNC;
      endcase

      if (clr_err) begin
         err_sticky_d = 1'b0;
         err_code_d   = ERR_NONE;
      end
      // A fresh violation overrides a clear issued on the same edge
      if (err_hit) begin
         err_pulse_d  = 1'b1;
         err_sticky_d = 1'b1;
         err_code_d   = err_new;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q      <= UNSYNC;
         phase_q      <= RED;
         err_pulse_q  <= 1'b0;
         err_sticky_q <= 1'b0;
         err_code_q   <= ERR_NONE;
         seq_count_q  <= '0;
      end else begin
         state_q      <= state_d;
         phase_q      <= phase_d;
         err_pulse_q  <= err_pulse_d;
         err_sticky_q <= err_sticky_d;
         err_code_q   <= err_code_d;
         seq_count_q  <= seq_count_d;
      end
   end

   assign phase      = phase_q;
   assign locked     = (state_q == LOCKED);
   assign err_pulse  = err_pulse_q;
   assign err_sticky = err_sticky_q;
   assign err_code   = err_code_q;
   assign seq_count  = seq_count_q;

endmodule

// File: tb/tb_traffic_monitor.sv
// Randomised and directed bench for traffic_monitor against a behavioural
// model of the UK light sequence rules (dwell check follows TRAFFIC_MON_DWELL_EN).
module tb_traffic_monitor;

   localparam int CNT_W     = 8;
   localparam int MAX_DWELL = 4;
   localparam int CNT_MAX   = (1 << CNT_W) - 1;

`ifdef TRAFFIC_MON_DWELL_EN
   localparam bit DWELL_EN = 1'b1;
`else
   localparam bit DWELL_EN = 1'b0;
`endif

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             red = 1'b0;
   logic             amber = 1'b0;
   logic             green = 1'b0;
   logic             clr_err = 1'b0;
   logic [1:0]       phase;
   logic             locked;
   logic             err_pulse;
   logic             err_sticky;
   logic [1:0]       err_code;
   logic [CNT_W-1:0] seq_count;

   traffic_monitor #(.CNT_W(CNT_W), .MAX_DWELL(MAX_DWELL)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .red        (red),
      .amber      (amber),
      .green      (green),
      .clr_err    (clr_err),
      .phase      (phase),
      .locked     (locked),
      .err_pulse  (err_pulse),
      .err_sticky (err_sticky),
      .err_code   (err_code),
      .seq_count  (seq_count)
   );

   always #5 clk = ~clk;

   // Legal lamp patterns indexed by phase number, {green, amber, red}
   logic [2:0] lamp_of [4] = '{3'b001, 3'b011, 3'b100, 3'b010};

   int total = 0;
   int bad   = 0;
   int cycle = 0;
   int dwell_errs = 0;

   // Behavioural model state
   bit m_sync;
   int m_phase;
   int m_hold;
   int m_count;
   bit m_pulse;
   bit m_sticky;
   int m_code;

   task automatic check(input string tag, input int got, input int exp);
      total++;
      if (got != exp) begin
         bad++;
         $display("FAIL %s cycle=%0d got=%0d exp=%0d", tag, cycle, got, exp);
      end
   endtask

   // Phase index of a pattern, or -1 if the pattern is not a legal lamp state
   function automatic int phase_of(input logic [2:0] pat);
      for (int i = 0; i < 4; i++) begin
         if (lamp_of[i] == pat) return i;
      end
      return -1;
   endfunction

   task automatic model_step(input bit rn, input logic [2:0] pat, input bit clr);
      int p;
      int err;
      if (!rn) begin
         m_sync = 0; m_phase = 0; m_hold = 0; m_count = 0;
         m_pulse = 0; m_sticky = 0; m_code = 0;
         return;
      end
      p   = phase_of(pat);
      err = 0;
      if (!m_sync) begin
         if (p < 0) err = 1;
         else if (p == 0) begin
            m_sync = 1; m_phase = 0; m_hold = 0;
         end
      end else if (p < 0) begin
         err = 1;
      end else if (p == m_phase) begin
         m_hold++;
         if (DWELL_EN && m_hold >= MAX_DWELL) err = 3;
      end else if (p == (m_phase + 1) % 4) begin
         if (m_phase == 3 && m_count < CNT_MAX) m_count++;
         m_phase = p;
         m_hold  = 0;
      end else begin
         err = 2;
      end
      if (err != 0) m_sync = 0;
      if (err == 3) dwell_errs++;
      if (clr) begin
         m_sticky = 0; m_code = 0;
      end
      m_pulse = (err != 0);
      if (err != 0) begin
         m_sticky = 1; m_code = err;
      end
   endtask

   task automatic step(input bit rn, input logic [2:0] pat, input bit clr);
      @(negedge clk);
      rst_n = rn;
      {green, amber, red} = pat;
      clr_err = clr;
      @(posedge clk);
      model_step(rn, pat, clr);
      cycle++;
      #1;
      check("phase",      int'(phase),      m_phase);
      check("locked",     int'(locked),     int'(m_sync));
      check("err_pulse",  int'(err_pulse),  int'(m_pulse));
      check("err_sticky", int'(err_sticky), int'(m_sticky));
      check("err_code",   int'(err_code),   m_code);
      check("seq_count",  int'(seq_count),  m_count);
   endtask

   task automatic run_cycle_seq();
      for (int i = 0; i < 4; i++) step(1'b1, lamp_of[i], 1'b0);
   endtask

   initial begin
      int cur;
      int r;
      logic [2:0] pat;

      // Reset and one full legal sequence
      step(1'b0, 3'b111, 1'b0);
      step(1'b0, 3'b000, 1'b0);
      run_cycle_seq();
      step(1'b1, lamp_of[0], 1'b0);
      check("seq_after_first", int'(seq_count), 1);
      $display("scenario legal sequence: seq_count=%0d locked=%0d", seq_count, locked);

      // Bad transition from GREEN, then re-lock
      step(1'b1, lamp_of[1], 1'b0);
      step(1'b1, lamp_of[2], 1'b0);
      step(1'b1, 3'b011, 1'b0);
      check("trans_code", int'(err_code), 2);
      step(1'b1, lamp_of[0], 1'b0);
      step(1'b1, lamp_of[0], 1'b0);
      $display("scenario bad transition: err_code=%0d locked=%0d", err_code, locked);

      // Illegal pattern while locked, then in UNSYNC with a clear on the same edge
      step(1'b1, 3'b111, 1'b0);
      step(1'b1, 3'b111, 1'b1);
      step(1'b1, lamp_of[2], 1'b1);
      step(1'b1, lamp_of[2], 1'b0);
      $display("scenario illegal pattern and clear: err_sticky=%0d", err_sticky);

      // Dwell: hold RED for six samples
      step(1'b1, 3'b110, 1'b1);
      step(1'b1, lamp_of[3], 1'b1);
      r = dwell_errs;
      for (int i = 0; i < 6; i++) step(1'b1, lamp_of[0], 1'b0);
      check("dwell_count", dwell_errs - r, DWELL_EN ? 1 : 0);
      $display("scenario red hold: err_code=%0d locked=%0d", err_code, locked);

      // Saturation over 300 full sequences
      step(1'b0, 3'b000, 1'b0);
      step(1'b1, lamp_of[0], 1'b0);
      for (int n = 0; n < 300; n++) begin
         for (int i = 1; i < 4; i++) step(1'b1, lamp_of[i], 1'b0);
         step(1'b1, lamp_of[0], 1'b0);
      end
      check("seq_saturated", int'(seq_count), CNT_MAX);
      $display("scenario saturation: seq_count=%0d", seq_count);

      // Reset while locked in AMBER with a sticky error
      step(1'b1, 3'b000, 1'b0);
      for (int i = 0; i < 4; i++) step(1'b1, lamp_of[i], 1'b0);
      step(1'b0, lamp_of[3], 1'b0);
      $display("scenario reset mid-sequence: locked=%0d err_sticky=%0d", locked, err_sticky);

      // Randomised mostly-legal traffic with glitches, jumps, clears and resets
      cur = 0;
      for (int n = 0; n < 3000; n++) begin
         r = $urandom_range(0, 99);
         if (r < 4) pat = 3'($urandom_range(0, 7));
         else if (r < 8) begin
            cur = $urandom_range(0, 3);
            pat = lamp_of[cur];
         end else if (r < 55) begin
            cur = (cur + 1) % 4;
            pat = lamp_of[cur];
         end else pat = lamp_of[cur];
         step(($urandom_range(0, 199) != 0), pat, ($urandom_range(0, 15) == 0));
      end
      $display("scenario random: cycles=%0d dwell_errs=%0d", cycle, dwell_errs);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/traffic_monitor.md
# traffic_monitor

Observer/checker for the UK traffic-light sequencer outputs. It samples the `red`, `amber` and `green` lamp lines and decodes them into a phase number. It checks every lamp pattern and every phase transition against the legal UK sequence, reports violations, and counts completed light cycles. It sits beside the sequencer in the top level as a self-check and a status source.

## Interface
Parameters:
- `CNT_W`, default 8: width of the completed-cycle counter.
- `MAX_DWELL`, default 16: maximum cycles a phase may be held. Used only with `TRAFFIC_MON_DWELL_EN`; legal range 1 to 65535.

Ports:
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  synchronous reset, active-low.
- `red`  in  1  red lamp line, synchronous to `clk`.
- `amber`  in  1  amber lamp line.
- `green`  in  1  green lamp line.
- `clr_err`  in  1  clears `err_sticky` and `err_code`.
- `phase`  out  2  decoded phase: 0 RED, 1 RED_AMBER, 2 GREEN, 3 AMBER.
- `locked`  out  1  monitor is synchronised to the sequence.
- `err_pulse`  out  1  one-cycle strobe on each violation.
- `err_sticky`  out  1  set by any violation; held until `clr_err`.
- `err_code`  out  2  code of the most recent violation: 0 none, 1 bad pattern, 2 bad transition, 3 dwell timeout.
- `seq_count`  out  CNT_W  completed AMBER→RED cycles while locked; saturates.

## Operation
- Lamp pattern is {green, amber, red}. Legal patterns:
  - 001 = RED
  - 011 = RED_AMBER
  - 100 = GREEN
  - 010 = AMBER
- Illegal patterns: 000, 101, 110, 111.
- State machine with two states, UNSYNC and LOCKED. A phase register tracks the last legal phase.
- UNSYNC:
  - Ignores transitions.
  - An illegal pattern raises a bad-pattern error (code 1) and stays in UNSYNC.
  - Pattern RED moves to LOCKED with `phase`=0.
  - Any other legal pattern stays in UNSYNC with no error.
- LOCKED: each sampled pattern is compared with the held phase.
  - Same phase: legal hold.
  - Successor phase: legal; update `phase`. Successors are RED→RED_AMBER, RED_AMBER→GREEN, GREEN→AMBER, AMBER→RED.
  - Illegal pattern: code 1; go to UNSYNC.
  - Any other legal phase: bad transition, code 2; go to UNSYNC.
- In UNSYNC, `phase` holds its last value.
- On any error, `err_pulse`=1 for exactly that cycle, `err_sticky`=1, and `err_code` is updated.
- `seq_count` increments on each legal AMBER→RED while LOCKED. It stops at 2^CNT_W−1 and does not wrap.
- Reset values: `phase`=0, `locked`=0, `err_pulse`=0, `err_sticky`=0, `err_code`=0, `seq_count`=0, dwell counter=0.

## Timing
- Inputs are sampled on every rising edge of `clk`. All outputs are registered and reflect the pattern sampled at the previous edge (latency 1).
- `clr_err` takes effect on the next edge. If a new error occurs on the same edge, the new error wins: `err_sticky` stays 1 and `err_code` takes the new code.
- `rst_n`=0 sampled on an edge forces all reset values on that edge, regardless of state or of other inputs, including mid-sequence.
- After reset or any error, re-lock needs one sampled RED. `locked` rises one cycle after that RED is sampled.
- Leaving LOCKED on an error: `locked` falls on the same edge that `err_pulse` rises.

## Configuration
- Macro: `TRAFFIC_MON_DWELL_EN`.
- Defined:
  - A dwell counter of width `$clog2(MAX_DWELL+1)` resets to 0 on each phase change and on lock.
  - It increments while LOCKED and the phase is held.
  - On the cycle where a held phase has lasted `MAX_DWELL` cycles beyond its first sample, the monitor raises a dwell timeout (code 3), pulses `err_pulse` once, and drops to UNSYNC.
- Undefined: no dwell counter; holds of any length are legal; code 3 is never produced.

## Structure
- Shared package `traffic_pkg` holds:
  - phase encoding constants (RED, RED_AMBER, GREEN, AMBER);
  - lamp pattern constants (001, 011, 100, 010);
  - error code constants (ERR_NONE, ERR_PATTERN, ERR_TRANS, ERR_DWELL);
  - monitor state constants (UNSYNC, LOCKED).
- Sub-module `light_decode`: combinational. Maps the 3-bit pattern to a 2-bit phase plus a `legal` flag. It is reusable by the sequencer's own testbench.

## Test plan
- Reset, then the full legal sequence RED,RED_AMBER,GREEN,AMBER,RED, one per cycle → `locked`=1 one cycle after the first RED; `phase` steps 0,1,2,3,0; `seq_count`=1; no error.
- While locked in GREEN, drive 011 (RED_AMBER) → `err_pulse`=1 for one cycle; `err_code`=2; `locked`=0; the next RED re-locks.
- Drive 111 in UNSYNC and in LOCKED → `err_code`=1 each time; `err_sticky`=1 until `clr_err`. Assert `clr_err` on the same cycle as a new error → `err_sticky` stays 1.
- Run 300 legal cycles with `CNT_W`=8 → `seq_count` saturates at 255.
- With `TRAFFIC_MON_DWELL_EN` and `MAX_DWELL`=4, hold RED for 6 cycles → `err_code`=3 once; `locked`=0. Without the macro, the same stimulus gives no error.
- Assert `rst_n`=0 while locked in AMBER with `err_sticky`=1 → all outputs return to reset values on the next edge.
